// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider scheduler.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } div_state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_period_cnt.sv
// Period counter: generates cnt/oclk/tick for one divide ratio; load starts a
// period, step advances it, and with neither asserted the outputs are cleared.
module clk_div_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             oclk,
  output logic             tick,
  output logic             last
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] half;

  assign cnt_inc = cnt + 1'b1;
  assign half    = div >> 1;
  assign last    = (cnt == div - 1'b1);

  // oclk/tick are registered from the value cnt takes at the same edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      oclk <= 1'b0;
      tick <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      oclk <= 1'b1;
      tick <= 1'b1;
    end else if (step) begin
      cnt  <= cnt_inc;
      oclk <= (cnt_inc < half);
      tick <= 1'b0;
    end else begin
      cnt  <= '0;
      oclk <= 1'b0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time programmable clock-divider scheduler; ratio updates take effect only
// at period boundaries. Optional period counter under CLK_DIV_SCHED_CNT_EN.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_DEF = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             oclk,
  output logic             tick,
  output logic             busy,
  output logic             err
`ifdef CLK_DIV_SCHED_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend;
  logic             load;
  logic             step;
  logic             last;
  logic             apply_pend;
  logic             accept;
  logic             legal;

  assign cfg_ready = !pend;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && !pend;
  assign legal     = (cfg_div >= DIV_W'(DIV_MIN));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    step       = 1'b0;
    apply_pend = 1'b0;
    case (state)
      IDLE: begin
        apply_pend = pend;
        if (en) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          apply_pend = pend;
          if (en) load = 1'b1;
          else    state_nxt = STOP;
        end else begin
          step = 1'b1;
        end
      end
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // a pending ratio can only exist when no accept is possible, so the two never collide
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur_div <= DIV_W'(DIV_DEF);
      pend    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (apply_pend) begin
        cur_div <= pend_div;
        pend    <= 1'b0;
      end else if (accept && legal) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && legal) pend_div <= cfg_div;
  end

  clk_div_period_cnt #(
    .DIV_W(DIV_W)
  ) u_period_cnt (
    .clk  (clk),
    .rstn (rstn),
    .load (load),
    .step (step),
    .div  (cur_div),
    .oclk (oclk),
    .tick (tick),
    .last (last)
  );

`ifdef CLK_DIV_SCHED_CNT_EN
  // increments on the same edge that raises tick
  always_ff @(posedge clk) begin
    if (!rstn)     period_cnt <= '0;
    else if (load) period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed vector table, corner-case sequences and
// randomized traffic checked against a period-level waveform model.
module tb_clk_div_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       oclk;
  logic       tick;
  logic       busy;
  logic       err;
`ifdef CLK_DIV_SCHED_CNT_EN
  logic [15:0] period_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_sched #(
    .DIV_W   (8),
    .DIV_DEF (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .oclk      (oclk),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
`ifdef CLK_DIV_SCHED_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  // Reference model: a whole period's {tick,oclk} samples are queued when it starts.
  bit         m_run, m_stop, m_pend;
  int         m_div, m_pdiv;
  bit         e_tick, e_oclk, e_err;
  logic [1:0] q[$];

  task automatic start_period();
    m_run = 1'b1;
    q.delete();
    for (int i = 0; i < m_div; i++) q.push_back({(i == 0), (i < m_div / 2)});
    {e_tick, e_oclk} = q.pop_front();
  endtask

  task automatic model_edge();
    bit acc;
    acc = cfg_valid && !m_pend;
    if (!rstn) begin
      m_run = 0; m_stop = 0; m_pend = 0; m_div = 3;
      q.delete();
      e_tick = 0; e_oclk = 0; e_err = 0;
      return;
    end
    e_err = acc && (cfg_div < 2);
    if (m_stop) begin
      m_stop = 0; e_tick = 0; e_oclk = 0;
    end else if (!m_run) begin
      if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
      if (en) start_period();
      else begin e_tick = 0; e_oclk = 0; end
    end else if (q.size() > 0) begin
      {e_tick, e_oclk} = q.pop_front();
    end else begin
      if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
      if (en) start_period();
      else begin m_run = 0; m_stop = 1; e_tick = 0; e_oclk = 0; end
    end
    if (acc && cfg_div >= 2) begin m_pend = 1; m_pdiv = cfg_div; end
  endtask

  function automatic logic [4:0] outs();
    return {tick, oclk, cfg_ready, busy, err};
  endfunction

  function automatic logic [4:0] mexp();
    return {e_tick, e_oclk, !m_pend, (m_run || m_stop), e_err};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b ({tick,oclk,cfg_ready,busy,err}) t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step_in(input logic r, input logic e, input logic v, input logic [7:0] d);
    rstn = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle(input logic r, input logic e, input logic v, input logic [7:0] d,
                       input string name);
    step_in(r, e, v, d);
    check(name, outs(), mexp());
  endtask

  typedef struct {
    logic       rstn;
    logic       en;
    logic       v;
    logic [7:0] d;
    logic [4:0] exp;
  } vec_t;

  function automatic vec_t vec(input logic r, input logic e, input logic v,
                               input logic [7:0] d, input logic [4:0] exp);
    vec_t t;
    t.rstn = r; t.en = e; t.v = v; t.d = d; t.exp = exp;
    return t;
  endfunction

  vec_t tbl[24];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] seen;
    bit ren;

    rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

    // exp = {tick, oclk, cfg_ready, busy, err}
    tbl[0]  = vec(0, 0, 0, 8'd0, 5'b00100);  // reset
    tbl[1]  = vec(1, 1, 0, 8'd0, 5'b11110);  // N=3 period start
    tbl[2]  = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[3]  = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[4]  = vec(1, 1, 0, 8'd0, 5'b11110);
    tbl[5]  = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[6]  = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[7]  = vec(1, 1, 0, 8'd0, 5'b11110);
    tbl[8]  = vec(1, 1, 1, 8'd1, 5'b00111);  // N=1 rejected
    tbl[9]  = vec(1, 1, 1, 8'd0, 5'b00111);  // N=0 rejected
    tbl[10] = vec(1, 1, 0, 8'd0, 5'b11110);  // still N=3
    tbl[11] = vec(1, 1, 1, 8'd4, 5'b00010);  // N=4 pending
    tbl[12] = vec(1, 1, 0, 8'd0, 5'b00010);
    tbl[13] = vec(1, 1, 0, 8'd0, 5'b11110);  // N=4 applied: 1,1,0,0
    tbl[14] = vec(1, 1, 0, 8'd0, 5'b01110);
    tbl[15] = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[16] = vec(1, 1, 0, 8'd0, 5'b00110);
    tbl[17] = vec(1, 1, 0, 8'd0, 5'b11110);
    tbl[18] = vec(1, 0, 0, 8'd0, 5'b01110);  // en dropped, period completes
    tbl[19] = vec(1, 0, 0, 8'd0, 5'b00110);
    tbl[20] = vec(1, 0, 0, 8'd0, 5'b00110);
    tbl[21] = vec(1, 0, 0, 8'd0, 5'b00110);  // STOP
    tbl[22] = vec(1, 0, 0, 8'd0, 5'b00100);  // IDLE
    tbl[23] = vec(1, 1, 0, 8'd0, 5'b11110);  // restart keeps N=4

    for (int i = 0; i < 24; i++) begin
      step_in(tbl[i].rstn, tbl[i].en, tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // en dropped after the first cycle of an N=5 period
    cycle(0, 0, 0, 8'd0, "n5_reset");
    cycle(1, 0, 1, 8'd5, "n5_cfg");
    cycle(1, 0, 0, 8'd0, "n5_idle_apply");
    cycle(1, 1, 0, 8'd0, "n5_start");
    n = 0;
    while (busy && n < 20) begin
      cycle(1, 0, 0, 8'd0, "n5_drain");
      n++;
    end
    check_val("n5_cycles_to_idle", n, 6);
    check_val("n5_oclk_idle", int'(oclk), 0);

    // ratio accepted in the boundary cycle lands one period later
    cycle(0, 0, 0, 8'd0, "b6_reset");
    cycle(1, 1, 0, 8'd0, "b6_start");
    cycle(1, 1, 0, 8'd0, "b6_c1");
    cycle(1, 1, 0, 8'd0, "b6_c2");
    cycle(1, 1, 1, 8'd6, "b6_boundary_accept");
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      cycle(1, 1, 0, 8'd0, "b6_run");
      seen[i] = tick;
    end
    check_val("b6_tick_positions", int'(seen), int'(9'b1_0000_0100));
    cycle(1, 1, 0, 8'd0, "b6_mid");
    cycle(0, 1, 0, 8'd0, "b6_rst_mid");
    check_val("b6_rst_oclk", int'(oclk), 0);
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 8'd0, "b6_after_rst_n3");

    // randomized traffic
    ren = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) ren = !ren;
      cycle(($urandom_range(0, 199) != 0), ren, ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 9)), "rand");
    end

`ifdef CLK_DIV_SCHED_CNT_EN
    cycle(0, 0, 0, 8'd0, "pc_reset");
    check_val("pc_reset_val", int'(period_cnt), 0);
    for (int i = 0; i < 28; i++) cycle(1, 1, 0, 8'd0, "pc_run");
    check_val("pc_ten_periods", int'(period_cnt), 10);
    force dut.period_cnt = 16'hFFFF;
    #1;
    release dut.period_cnt;
    n = 0;
    do begin
      cycle(1, 1, 0, 8'd0, "pc_wrap_run");
      n++;
    end while (!tick && n < 10);
    check_val("pc_wrap", int'(period_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
